neo_counter_n: RTL
==================

NEO_COUNTER_N -- requirements
Module: neo_counter_n

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits; SHALL be a multiple of 4, range 4..32.
REQ-002 Parameter MODULO, default 0: 0 = natural 2^WIDTH wrap; nonzero = count range 0..MODULO-1, with 2 <= MODULO <= 2^WIDTH.
REQ-003 CK  input  1  sole clock; all state updates on rising edge.
REQ-004 CL  input  1  reset, asynchronous, active-high.
REQ-005 D  input  WIDTH  parallel load data.
REQ-006 nL  input  1  synchronous load, active-low.
REQ-007 EN  input  1  count enable.
REQ-008 CI  input  1  carry-in, for cascading.
REQ-009 UP  input  1  direction: 1 = up, 0 = down.
REQ-010 RLD  input  1  auto-reload mode select.
REQ-011 Q  output  WIDTH  counter value, registered.
REQ-012 CO  output  1  carry-out, combinational.
REQ-013 TC  output  1  registered terminal-count pulse.

Function
REQ-014 A count event SHALL be a rising CK edge with nL=1, EN=1 and CI=1.
REQ-015 Load SHALL take priority over counting: when nL=0, Q and reload register R both take D, regardless of EN, CI, UP and RLD.
REQ-016 TERM SHALL be the terminal value for the current direction:
- UP=1: TERM = MODULO-1 when MODULO is nonzero, otherwise 2^WIDTH-1.
- UP=0: TERM = 0.
REQ-017 On a count event with Q != TERM:
- UP=1: Q <= Q+1, modulo 2^WIDTH.
- UP=0: Q <= Q-1.
REQ-018 On a count event with Q == TERM and RLD=0:
- UP=1: Q <= 0.
- UP=0: Q <= MODULO-1 when MODULO is nonzero, otherwise 2^WIDTH-1.
REQ-019 On a count event with Q == TERM and RLD=1, Q SHALL take R, in either direction.
REQ-020 Out-of-range values SHALL not be corrected.
- A loaded value >= MODULO is kept as loaded.
- Counting up from such a value proceeds through 2^WIDTH-1 and then wraps to 0.
- Counting down from such a value decrements normally.
REQ-021 CO SHALL equal CI AND (Q == TERM), evaluated combinationally from the current Q and UP.
REQ-022 TC SHALL be 1 for exactly the one cycle following a count event taken at Q == TERM, and 0 otherwise.
REQ-023 A load in the same cycle as a terminal condition SHALL suppress the TC pulse.
REQ-024 With no load and no count event, Q, R and TC SHALL hold, except that TC returns to 0.
REQ-025 Changing UP between cycles SHALL take effect on the next edge; no extra latency.

Reset
REQ-026 While CL=1: Q=0, R=0, TC=0, independent of CK.
REQ-027 CO SHALL follow REQ-021 during reset, so CO = CI when UP=0, since Q=0.
REQ-028 Deasserting CL mid-sequence SHALL resume from Q=0; the first edge after release behaves per REQ-014..REQ-019.

Structure
REQ-029 Shared package neo_cnt_pkg SHALL hold:
- direction constants DIR_UP and DIR_DOWN;
- localparam helper functions for the TERM/max value from WIDTH and MODULO.
REQ-030 The counter SHALL be built from WIDTH/4 instances of one sub-module, neo_cnt_slice4.
- neo_cnt_slice4 is a 4-bit up/down loadable slice with per-slice carry/borrow.
- Slice carries chain combinationally within one cycle.
- Modulo/reload override logic sits at top level.

Verification
REQ-031 WIDTH=8, MODULO=0, UP=1, RLD=0: load 0xFE, then 3 count edges -> Q = 0xFF, 0x00, 0x01; TC=1 only in the cycle after the 0xFF->0x00 edge.
REQ-032 WIDTH=8, MODULO=10, UP=0, RLD=0: load 0x01, then 3 count edges -> Q = 0, 9, 8; CO=1 while Q=0 and CI=1.
REQ-033 WIDTH=12, RLD=1, UP=1: load 0xFFD, then 3 count edges -> Q = 0xFFE, 0xFFF, 0xFFD (reload); TC pulses once.
REQ-034 nL=0 with EN=CI=1 and Q at TERM -> Q=D, no wrap, TC stays 0.
REQ-035 Two 4-bit-cascaded style check, WIDTH=16: set CI=0 with EN=1 -> Q holds and CO=0; then CI=1 from 0x00FF up -> Q=0x0100.
REQ-036 Assert CL asynchronously mid-count at Q=0x37 -> Q=0 and TC=0 immediately; after release, first count event gives Q=1 (UP=1).

Source files
------------

// File: rtl/neo_cnt_pkg.sv
// Shared constants and elaboration-time helpers for the neo_counter_n family.
package neo_cnt_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // All-ones value of a WIDTH-bit counter, computed in 64 bits so WIDTH=32 is safe.
  function automatic logic [31:0] cnt_max(input int unsigned width);
    return 32'((64'd1 << width) - 64'd1);
  endfunction

  // Terminal value when counting up: MODULO-1, or the natural maximum when MODULO is 0.
  function automatic logic [31:0] cnt_term_up(input int unsigned width,
                                              input longint unsigned modulo);
    return (modulo != 64'd0) ? 32'(modulo - 64'd1) : cnt_max(width);
  endfunction

endpackage

// File: rtl/neo_cnt_slice4.sv
// 4-bit loadable up/down counter slice; carry/borrow ripples combinationally to the next slice.
module neo_cnt_slice4
  import neo_cnt_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] d_i,
  input  logic       cin_i,
  input  logic       up_i,
  output logic [3:0] q_o,
  output logic       cout_o
);

  logic [3:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = d_i;
    end else if (cin_i) begin
      q_d = (up_i == DIR_DOWN) ? q_q - 4'd1 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= 4'h0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o    = q_q;
  assign cout_o = cin_i & ((up_i == DIR_DOWN) ? (q_q == 4'h0) : (q_q == 4'hF));

endmodule

// File: rtl/neo_counter_n.sv
// N-bit cascadable up/down counter with modulo limit, auto-reload and terminal-count pulse.
module neo_counter_n
  import neo_cnt_pkg::*;
#(
  parameter int unsigned     WIDTH  = 8,
  parameter longint unsigned MODULO = 0
) (
  input  logic             CK,
  input  logic             CL,
  input  logic [WIDTH-1:0] D,
  input  logic             nL,
  input  logic             EN,
  input  logic             CI,
  input  logic             UP,
  input  logic             RLD,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             TC
);

  localparam int unsigned      NumSlices = WIDTH / 4;
  localparam logic [WIDTH-1:0] TermUp    = WIDTH'(cnt_term_up(WIDTH, MODULO));

  logic [WIDTH-1:0]   term;
  logic [WIDTH-1:0]   load_val;
  logic [WIDTH-1:0]   r_q, r_d;
  logic               tc_q, tc_d;
  logic               at_term, cnt_ev, load_all;
  logic [NumSlices:0] carry;
  logic               unused_carry_out;

  always_comb begin
    term     = (UP == DIR_UP) ? TermUp : '0;
    at_term  = (Q == term);
    cnt_ev   = nL & EN & CI;
    // Wrap and reload are forced through the slices' parallel load path.
    load_all = ~nL | (cnt_ev & at_term);
    if (!nL) begin
      load_val = D;
    end else if (RLD) begin
      load_val = r_q;
    end else if (UP == DIR_UP) begin
      load_val = '0;
    end else begin
      load_val = TermUp;
    end
    r_d  = nL ? r_q : D;
    tc_d = cnt_ev & at_term;
  end

  assign carry[0] = cnt_ev;

  for (genvar i = 0; i < NumSlices; i++) begin : g_slice
    neo_cnt_slice4 u_slice (
      .clk_i  (CK),
      .rst_i  (CL),
      .load_i (load_all),
      .d_i    (load_val[4*i +: 4]),
      .cin_i  (carry[i]),
      .up_i   (UP),
      .q_o    (Q[4*i +: 4]),
      .cout_o (carry[i+1])
    );
  end

  assign unused_carry_out = carry[NumSlices];

  always_ff @(posedge CK or posedge CL) begin
    if (CL) begin
      r_q  <= '0;
      tc_q <= 1'b0;
    end else begin
      r_q  <= r_d;
      tc_q <= tc_d;
    end
  end

  assign CO = CI & at_term;
  assign TC = tc_q;

endmodule
